eh2_posit_mul_core: RTL and testbench
=====================================

// Module: eh2_posit_mul_core
// PURPOSE
//  Multi-cycle posit multiplier core. Sits directly downstream of the posit field decoders.
//  Takes two decoded operands (sign/regime/exponent/fraction/is_special) and produces the
//  unrounded product for the posit encoder: sign, signed scale, normalised fraction and
//  guard/round/sticky bits, plus zero/NaR flags. Iterative radix-2 shift-add, valid/ready both sides.
// PARAMETERS
//  POSIT_LEN    32                  posit width
//  ES           2                   exponent field width
//  REGIME_BW    $clog2(POSIT_LEN)   decoded regime width (two's complement)
//  FRACTION_BW  POSIT_LEN-ES-3      fraction bits per operand (hidden bit excluded)
//  MANT_BW      FRACTION_BW+1       mantissa with hidden 1
//  SCALE_BW     REGIME_BW+ES+2      signed product scale width
// PORTS
//  clk          in   1            clock
//  rst          in   1            synchronous reset, active-high
//  in_valid     in   1            operand pair valid
//  in_ready     out  1            core can accept an operand pair
//  a_sign/b_sign          in  1            operand sign
//  a_regime/b_regime      in  REGIME_BW    signed regime k
//  a_exp/b_exp            in  ES           exponent field
//  a_frac/b_frac          in  FRACTION_BW  fraction field
//  a_special/b_special    in  1            zero/NaR flag (NaR = special & sign)
//  out_valid    out  1            result valid
//  out_ready    in   1            consumer accepts result
//  out_sign     out  1            product sign = a_sign ^ b_sign
//  out_scale    out  SCALE_BW     signed scale = (ka<<ES)+ea+(kb<<ES)+eb+norm
//  out_frac     out  FRACTION_BW  product fraction below hidden bit
//  out_grs      out  3            guard, round, sticky (sticky = OR of all lower bits)
//  out_zero     out  1            product is zero
//  out_nar      out  1            product is NaR
// BEHAVIOUR
//  - Reset: state=IDLE, in_ready=1, out_valid=0, all out_* data=0.
//  - Accept on in_valid&in_ready; capture operands and in the same edge drop in_ready.
//  - FSM IDLE -> MUL -> NORM -> DONE -> IDLE.
//    IDLE: wait for accept. If either special: skip to DONE (latency 1).
//    MUL: MANT_BW cycles, counter 0..MANT_BW-1; each cycle add multiplicand if multiplier LSB=1,
//      shift 2*MANT_BW-bit accumulator right. Scale sum computed in parallel, sign-extended to SCALE_BW.
//    NORM: product in [1,4). If bit 2*MANT_BW-1 set: scale+1, take fraction from next bits;
//      else take fraction one bit lower. G, R = next two bits; S = OR of remainder.
//    DONE: out_valid=1; outputs stable while out_ready=0. On out_valid&out_ready -> IDLE, in_ready=1 next cycle.
//  - Normal latency accept->out_valid: MANT_BW+2 cycles. No overlap: one operation in flight.
//  - Specials: NaR if any operand has special&sign (NaR wins over zero). Else zero if any special.
//    Special results: out_frac=0, out_grs=0, out_scale=0, out_sign=0.
//  - Scale never saturates here; the encoder clamps to maxpos/minpos.
//  - rst asserted in any state: back to IDLE next edge; in-flight result discarded, out_valid=0.
//  - in_valid while busy: ignored (in_ready=0). Inputs need not be held after accept.
// STRUCTURE
//  - Shared package eh2_posit_pkg: POSIT_LEN/ES defaults, derived widths (REGIME_BW, FRACTION_BW,
//    MANT_BW, SCALE_BW), FSM state enum posit_mul_state_t, decoded-operand struct posit_dec_t.
//  - One natural sub-module: eh2_posit_mant_mul (iterative shift-add mantissa multiplier,
//    start/done handshake). Scale adder, normaliser and special logic live in this core.
// TESTING (POSIT_LEN=32, ES=2)
//  - 1.0*1.0: k=0,e=0,f=0 both -> out_valid after 30 cycles; sign0, scale0, frac0, grs=000.
//  - 1.5*1.5: f=27'h4000000 both -> scale=1, frac=27'h1000000 (1.125), grs=000.
//  - -2.0*0.25: a sign1 k0 e1; b k-1 e2 -> sign1, scale=-1, frac0.
//  - Zero*NaR and NaR*3.0 -> out_nar=1 after 1 cycle; zero*5.0 -> out_zero=1, out_nar=0.
//  - out_ready held 0 for 10 cycles in DONE -> outputs stable, in_ready=0, then one handshake -> IDLE.
//  - rst pulsed mid-MUL (cycle 10) -> out_valid stays 0, in_ready=1 next cycle; new 1.0*1.0 correct.

Source files
------------

// File: rtl/eh2_posit_pkg.sv
// Shared posit definitions: widths derived from POSIT_LEN/ES, multiplier FSM states,
// decoded-operand bundle and a scale helper.
// Contents: POSIT_LEN, ES, REGIME_BW, FRACTION_BW, MANT_BW, SCALE_BW, posit_mul_state_t,
// posit_dec_t, op_scale().
package eh2_posit_pkg;

  localparam int POSIT_LEN   = 32;
  localparam int ES          = 2;
  localparam int REGIME_BW   = $clog2(POSIT_LEN);
  localparam int FRACTION_BW = POSIT_LEN - ES - 3;
  localparam int MANT_BW     = FRACTION_BW + 1;
  localparam int SCALE_BW    = REGIME_BW + ES + 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_NORM = 2'd2,
    ST_DONE = 2'd3
  } posit_mul_state_t;

  // One operand as produced by the posit field decoder.
  typedef struct packed {
    logic                   sign;
    logic [REGIME_BW-1:0]   regime;   // two's complement k
    logic [ES-1:0]          exp;
    logic [FRACTION_BW-1:0] frac;
    logic                   special;  // zero, or NaR when sign is also set
  } posit_dec_t;

  // Operand scale (k << ES) + e, sign-extended to the product scale width.
  function automatic logic [SCALE_BW-1:0] op_scale(input logic [REGIME_BW-1:0] k,
                                                   input logic [ES-1:0]        e);
    logic [SCALE_BW-1:0] k_ext;
    k_ext = {{(SCALE_BW-REGIME_BW){k[REGIME_BW-1]}}, k};
    return (k_ext << ES) + {{(SCALE_BW-ES){1'b0}}, e};
  endfunction

endpackage

// File: rtl/eh2_posit_mant_mul.sv
// Iterative radix-2 shift-add unsigned multiplier: W x W -> 2W product.
// Latency: start pulse, then W busy cycles; done is high during the last busy cycle.
// Backpressure: none; start is only issued by the owner when the unit is idle.
// Ports: clk, rst (sync, active-high), start, mcand, mplier, done, product.
module eh2_posit_mant_mul
  import eh2_posit_pkg::*;
#(
  parameter int W = MANT_BW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [W-1:0]   mcand,
  input  logic [W-1:0]   mplier,
  output logic           done,
  output logic [2*W-1:0] product
);

  localparam int CNT_BW = $clog2(W);
  localparam logic [CNT_BW-1:0] LAST = CNT_BW'(W - 1);

  // Accumulator upper half holds the partial product, lower half starts as the
  // multiplier and is consumed LSB-first as the partial product shifts in.
  logic [2*W-1:0]    acc_q;
  logic [W-1:0]      mcand_q;
  logic [CNT_BW-1:0] cnt_q;
  logic              busy_q;
  logic [W:0]        sum;

  always_comb begin
    sum = {1'b0, acc_q[2*W-1:W]};
    if (acc_q[0]) begin
      sum = sum + {1'b0, mcand_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else if (start) begin
      acc_q   <= {{W{1'b0}}, mplier};
      mcand_q <= mcand;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else if (busy_q) begin
      // Carry out of the add becomes the new MSB as everything shifts right.
      acc_q <= {sum, acc_q[W-1:1]};
      cnt_q <= cnt_q + 1'b1;
      if (cnt_q == LAST) begin
        busy_q <= 1'b0;
      end
    end
  end

  assign done    = busy_q && (cnt_q == LAST);
  assign product = acc_q;

endmodule

// File: rtl/eh2_posit_mul_core.sv
// Multi-cycle posit multiplier core: decoded operands in, unrounded product (sign, scale,
// fraction, guard/round/sticky, zero/NaR) out for the encoder.
// Latency: MANT_BW+2 edges for normal operands, 1 edge for specials; one op in flight.
// Backpressure: in_ready low while busy; result held stable in DONE until out_ready.
// Ports: clk, rst (sync, active-high); in_valid/in_ready + a_*/b_* operand fields;
// out_valid/out_ready + out_sign, out_scale, out_frac, out_grs, out_zero, out_nar.
module eh2_posit_mul_core
  import eh2_posit_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   a_sign,
  input  logic [REGIME_BW-1:0]   a_regime,
  input  logic [ES-1:0]          a_exp,
  input  logic [FRACTION_BW-1:0] a_frac,
  input  logic                   a_special,
  input  logic                   b_sign,
  input  logic [REGIME_BW-1:0]   b_regime,
  input  logic [ES-1:0]          b_exp,
  input  logic [FRACTION_BW-1:0] b_frac,
  input  logic                   b_special,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_sign,
  output logic [SCALE_BW-1:0]    out_scale,
  output logic [FRACTION_BW-1:0] out_frac,
  output logic [2:0]             out_grs,
  output logic                   out_zero,
  output logic                   out_nar
);

  localparam int PW = 2 * MANT_BW;

  posit_mul_state_t state_q, state_d;

  logic            accept;
  logic            any_special;
  logic            any_nar;
  logic            mul_start;
  logic            mul_done;
  logic [PW-1:0]   product;

  logic                sign_q;
  logic [SCALE_BW-1:0] scale_sum_q;

  logic                   norm_hi;
  logic [FRACTION_BW-1:0] norm_frac;
  logic [2:0]             norm_grs;

  assign accept      = in_valid && in_ready;
  assign any_nar     = (a_special && a_sign) || (b_special && b_sign);
  assign any_special = a_special || b_special;
  assign mul_start   = accept && !any_special;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Specials need no arithmetic: their result is ready on the accept edge.
          state_d = any_special ? ST_DONE : ST_MUL;
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          state_d = ST_NORM;
        end
      end
      ST_NORM: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // ------------------------------------------------- mantissa multiplier
  eh2_posit_mant_mul #(
    .W(MANT_BW)
  ) u_mant_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .mcand   ({1'b1, a_frac}),
    .mplier  ({1'b1, b_frac}),
    .done    (mul_done),
    .product (product)
  );

  // --------------------------------------------------------- normaliser
  // Both mantissas are in [1,2), so the product is in [1,4) with the binary
  // point below bit PW-2. A set top bit means the value is >= 2: the hidden
  // bit moves up one place and the scale gains one.
  assign norm_hi = product[PW-1];

  always_comb begin
    norm_frac = '0;
    norm_grs  = '0;
    if (norm_hi) begin
      norm_frac   = product[PW-2 -: FRACTION_BW];
      norm_grs[2] = product[MANT_BW-1];
      norm_grs[1] = product[MANT_BW-2];
      norm_grs[0] = |product[MANT_BW-3:0];
    end else begin
      norm_frac   = product[PW-3 -: FRACTION_BW];
      norm_grs[2] = product[MANT_BW-2];
      norm_grs[1] = product[MANT_BW-3];
      norm_grs[0] = |product[MANT_BW-4:0];
    end
  end

  // --------------------------------------------------- datapath registers
  // Operands are not held after accept: sign and scale sum are folded at the
  // accept edge and the mantissas live inside the multiplier.
  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q      <= 1'b0;
      scale_sum_q <= '0;
      out_sign    <= 1'b0;
      out_scale   <= '0;
      out_frac    <= '0;
      out_grs     <= '0;
      out_zero    <= 1'b0;
      out_nar     <= 1'b0;
    end else begin
      if (accept) begin
        sign_q      <= a_sign ^ b_sign;
        scale_sum_q <= op_scale(a_regime, a_exp) + op_scale(b_regime, b_exp);
        if (any_special) begin
          // NaR dominates zero; special results carry no magnitude or sign.
          out_sign  <= 1'b0;
          out_scale <= '0;
          out_frac  <= '0;
          out_grs   <= '0;
          out_nar   <= any_nar;
          out_zero  <= !any_nar;
        end
      end
      if (state_q == ST_NORM) begin
        out_sign  <= sign_q;
        out_scale <= scale_sum_q + {{(SCALE_BW-1){1'b0}}, norm_hi};
        out_frac  <= norm_frac;
        out_grs   <= norm_grs;
        out_zero  <= 1'b0;
        out_nar   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_eh2_posit_mul_core.sv
module tb_eh2_posit_mul_core;
  import eh2_posit_pkg::*;

  localparam int RW = 1 + SCALE_BW + FRACTION_BW + 3 + 2;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   in_valid;
  logic                   in_ready;
  logic                   a_sign, b_sign;
  logic [REGIME_BW-1:0]   a_regime, b_regime;
  logic [ES-1:0]          a_exp, b_exp;
  logic [FRACTION_BW-1:0] a_frac, b_frac;
  logic                   a_special, b_special;
  logic                   out_valid;
  logic                   out_ready;
  logic                   out_sign;
  logic [SCALE_BW-1:0]    out_scale;
  logic [FRACTION_BW-1:0] out_frac;
  logic [2:0]             out_grs;
  logic                   out_zero;
  logic                   out_nar;

  always #5 clk = ~clk;

  eh2_posit_mul_core dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_sign(a_sign), .a_regime(a_regime), .a_exp(a_exp), .a_frac(a_frac), .a_special(a_special),
    .b_sign(b_sign), .b_regime(b_regime), .b_exp(b_exp), .b_frac(b_frac), .b_special(b_special),
    .out_valid(out_valid), .out_ready(out_ready), .out_sign(out_sign), .out_scale(out_scale),
    .out_frac(out_frac), .out_grs(out_grs), .out_zero(out_zero), .out_nar(out_nar)
  );

  typedef struct {
    logic                   sign;
    int                     scale;
    logic [FRACTION_BW-1:0] frac;
    logic [2:0]             grs;
    logic                   zero;
    logic                   nar;
  } res_t;

  int   checks = 0;
  int   errors = 0;
  res_t exp_q[$];

  task automatic chk(input string name, input logic ok, input longint act, input longint req);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic posit_dec_t mk(input logic s, input int k, input int e,
                                    input logic [FRACTION_BW-1:0] f, input logic sp);
    posit_dec_t d;
    d.sign = s; d.regime = REGIME_BW'(k); d.exp = ES'(e); d.frac = f; d.special = sp;
    return d;
  endfunction

  function automatic res_t lit(input logic s, input int sc, input logic [FRACTION_BW-1:0] f,
                               input logic [2:0] g, input logic z, input logic n);
    res_t r;
    r.sign = s; r.scale = sc; r.frac = f; r.grs = g; r.zero = z; r.nar = n;
    return r;
  endfunction

  // Reference: real product of (1.f_a)*(1.f_b) as an integer, then read off the
  // bits below the leading one; scale from k*2^ES+e of each operand.
  function automatic res_t model(input posit_dec_t a, input posit_dec_t b);
    res_t r;
    longint unsigned ma, mb, p;
    int n, ka, kb, ea, eb;
    r = lit(0, 0, '0, '0, 0, 0);
    if (a.special || b.special) begin
      r.nar  = (a.special && a.sign) || (b.special && b.sign);
      r.zero = !r.nar;
      return r;
    end
    ma = (64'd1 << FRACTION_BW) | {37'd0, a.frac};
    mb = (64'd1 << FRACTION_BW) | {37'd0, b.frac};
    p  = ma * mb;
    n  = (p >= (64'd1 << (2*MANT_BW-1))) ? 1 : 0;
    ka = $signed(a.regime); kb = $signed(b.regime);
    ea = a.exp; eb = b.exp;
    r.sign   = a.sign ^ b.sign;
    r.scale  = ka * (1 << ES) + ea + kb * (1 << ES) + eb + n;
    r.frac   = FRACTION_BW'(p >> (FRACTION_BW + n));
    r.grs[2] = p[FRACTION_BW-1+n];
    r.grs[1] = p[FRACTION_BW-2+n];
    r.grs[0] = (p & ((64'd1 << (FRACTION_BW-2+n)) - 1)) != 0;
    return r;
  endfunction

  function automatic logic [RW-1:0] pack_res(input res_t r);
    return {r.sign, SCALE_BW'(r.scale), r.frac, r.grs, r.zero, r.nar};
  endfunction

  function automatic logic [RW-1:0] dut_res();
    return {out_sign, out_scale, out_frac, out_grs, out_zero, out_nar};
  endfunction

  // ------------------------------------------------ compare process
  logic [RW-1:0] snap;
  logic          holding = 1'b0;
  initial begin
    res_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        holding = 1'b0;
      end else if (out_valid) begin
        chk("busy_in_ready", in_ready == 1'b0, in_ready, 0);
        if (holding) chk("stall_stable", dut_res() == snap, dut_res(), snap);
        if (out_ready) begin
          holding = 1'b0;
          if (exp_q.size() == 0) begin
            chk("unexpected_result", 1'b0, dut_res(), 0);
          end else begin
            e = exp_q.pop_front();
            chk("model_result", dut_res() == pack_res(e), dut_res(), pack_res(e));
          end
        end else begin
          holding = 1'b1;
          snap    = dut_res();
        end
      end else begin
        holding = 1'b0;
      end
    end
  end

  // --------------------------------------------------------- driver
  task automatic drive(input posit_dec_t a, input posit_dec_t b);
    a_sign = a.sign; a_regime = a.regime; a_exp = a.exp; a_frac = a.frac; a_special = a.special;
    b_sign = b.sign; b_regime = b.regime; b_exp = b.exp; b_frac = b.frac; b_special = b.special;
  endtask

  // All directed tasks start and end 1 time unit after a rising edge.
  task automatic issue(input posit_dec_t a, input posit_dec_t b);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    chk("issue_ready", in_ready == 1'b1, in_ready, 1);
    drive(a, b);
    in_valid = 1'b1;
    exp_q.push_back(model(a, b));
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Latency counts the accept edge as 1.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1; lat++;
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_hs", in_ready == 1'b1, in_ready, 1);
  endtask

  task automatic expect_lit(input string name, input int lat, input int req_lat, input res_t r);
    chk({name, "_latency"}, lat == req_lat, lat, req_lat);
    chk({name, "_value"}, dut_res() == pack_res(r), dut_res(), pack_res(r));
  endtask

  function automatic posit_dec_t rand_op();
    posit_dec_t d;
    d.sign    = 1'($urandom_range(0, 1));
    d.regime  = REGIME_BW'($urandom);
    d.exp     = ES'($urandom);
    d.frac    = FRACTION_BW'($urandom);
    if ($urandom_range(0, 7) == 0) d.frac = '1;
    d.special = ($urandom_range(0, 7) == 0);
    return d;
  endfunction

  initial begin
    posit_dec_t one, one_half, neg_two, quarter, zero, nar, three, five, ra, rb;
    int lat;
    logic stayed_low;
    int guard;

    one      = mk(0, 0, 0, 27'h0, 0);
    one_half = mk(0, 0, 0, 27'h4000000, 0);
    neg_two  = mk(1, 0, 1, 27'h0, 0);
    quarter  = mk(0, -1, 2, 27'h0, 0);
    zero     = mk(0, 0, 0, 27'h0, 1);
    nar      = mk(1, 0, 0, 27'h0, 1);
    three    = mk(0, 0, 1, 27'h4000000, 0);
    five     = mk(0, 0, 2, 27'h2000000, 0);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(one, one);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_in_ready", in_ready == 1'b1, in_ready, 1);
    chk("reset_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("reset_outputs", dut_res() == '0, dut_res(), 0);

    issue(one, one);          wait_valid(lat);
    expect_lit("one_x_one", lat, 30, lit(0, 0, 27'h0, 3'b000, 0, 0));
    handshake();

    issue(one_half, one_half); wait_valid(lat);
    expect_lit("1p5_x_1p5", lat, 30, lit(0, 1, 27'h1000000, 3'b000, 0, 0));
    handshake();

    issue(neg_two, quarter);  wait_valid(lat);
    expect_lit("m2_x_0p25", lat, 30, lit(1, -1, 27'h0, 3'b000, 0, 0));
    handshake();

    issue(zero, nar);         wait_valid(lat);
    expect_lit("zero_x_nar", lat, 1, lit(0, 0, 27'h0, 3'b000, 0, 1));
    handshake();

    issue(nar, three);        wait_valid(lat);
    expect_lit("nar_x_3", lat, 1, lit(0, 0, 27'h0, 3'b000, 0, 1));
    handshake();

    issue(zero, five);        wait_valid(lat);
    expect_lit("zero_x_5", lat, 1, lit(0, 0, 27'h0, 3'b000, 1, 0));
    handshake();

    // Consumer stalls for 10 cycles in DONE.
    issue(one_half, one_half); wait_valid(lat);
    repeat (10) begin
      @(posedge clk); #1;
      chk("stall_out_valid", out_valid == 1'b1, out_valid, 1);
      chk("stall_in_ready", in_ready == 1'b0, in_ready, 0);
    end
    expect_lit("stall_1p5", lat, 30, lit(0, 1, 27'h1000000, 3'b000, 0, 0));
    handshake();

    // Reset in the middle of the multiply: result must be dropped.
    issue(one, one);
    repeat (9) begin @(posedge clk); #1; end
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid == 1'b0, out_valid, 0);
    chk("midrst_in_ready", in_ready == 1'b1, in_ready, 1);
    stayed_low = 1'b1;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) stayed_low = 1'b0;
    end
    chk("midrst_no_result", stayed_low == 1'b1, stayed_low, 1);
    issue(one, one);          wait_valid(lat);
    expect_lit("post_rst_one", lat, 30, lit(0, 0, 27'h0, 3'b000, 0, 0));
    handshake();

    // Random traffic with random backpressure and ignored requests while busy.
    for (int c = 0; c < 8000; c++) begin
      @(posedge clk); #1;
      in_valid  = 1'b0;
      out_ready = ($urandom_range(0, 3) != 0);
      if (in_ready && $urandom_range(0, 2) != 0) begin
        ra = rand_op(); rb = rand_op();
        drive(ra, rb);
        in_valid = 1'b1;
        exp_q.push_back(model(ra, rb));
      end else if (!in_ready && $urandom_range(0, 7) == 0) begin
        drive(rand_op(), rand_op());
        in_valid = 1'b1;
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(posedge clk); #1; guard++;
    end
    chk("drain_empty", exp_q.size() == 0, exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
